// File: rtl/sm510_lcd_capture.sv
// SM510 LCD frame capture: rebuilds 4-common frames into a double-buffered 4x33 bitmap, with a registered read port.
// Row write 2+SETTLE clk after H changes at the pins; frame_done one clk after the last row; freeze defers the swap.
module sm510_lcd_capture #(
    parameter int unsigned SETTLE  = 2,
    parameter logic [23:0] TIMEOUT = 24'd2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  H,
    input  logic [15:0] segA,
    input  logic [15:0] segB,
    input  logic        Bs,
    input  logic        freeze,
    input  logic [1:0]  rd_row,
    output logic [32:0] rd_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        seq_err,
    output logic        blank
);
    typedef enum logic [1:0] {IDLE, CAP, DONE} state_t;

    localparam logic [3:0] SET = SETTLE[3:0];

    state_t      state_q;
    logic [3:0]  h_q, h_prev_q;
    logic [32:0] seg_q;
    logic [3:0]  settle_q, settle_d;
    logic [23:0] tmo_q, tmo_d;
    logic [1:0]  expect_q;
    logic        sel_q;
    logic [32:0] buf_q [2][4];

    logic       h_chg, strobe, tmo_hit, swap;
    logic [1:0] idx;

    always_comb begin
        h_chg    = (h_q != h_prev_q);
        settle_d = h_chg ? 4'd0 : ((settle_q == SET) ? SET : settle_q + 4'd1);
        tmo_d    = h_chg ? 24'd0 : ((tmo_q == TIMEOUT) ? TIMEOUT : tmo_q + 24'd1);
        // Strobe on the single cycle the settle count is about to reach SETTLE.
        strobe   = !h_chg && (settle_q == SET - 4'd1) && $onehot(h_q);
        tmo_hit  = !h_chg && (tmo_q == TIMEOUT - 24'd1);
        swap     = (state_q == DONE) && !freeze;
        idx      = 2'd0;
        case (h_q)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            h_q        <= 4'd0;
            h_prev_q   <= 4'd0;
            seg_q      <= 33'd0;
            settle_q   <= 4'd0;
            tmo_q      <= 24'd0;
            expect_q   <= 2'd0;
            sel_q      <= 1'b0;
            rd_data    <= 33'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            seq_err    <= 1'b0;
            blank      <= 1'b1;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    buf_q[b][r] <= 33'd0;
                end
            end
        end else begin
            h_q        <= H;
            seg_q      <= {Bs, segB, segA};
            h_prev_q   <= h_q;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            // Registered before any swap lands, so a read never sees a half-switched buffer.
            rd_data    <= buf_q[sel_q][rd_row];
            case (state_q)
                IDLE: begin
                    if (strobe && idx == 2'd0) begin
                        buf_q[~sel_q][0] <= seg_q;
                        expect_q         <= 2'd1;
                        state_q          <= CAP;
                    end
                end
                CAP: begin
                    if (strobe) begin
                        if (idx == expect_q) begin
                            buf_q[~sel_q][idx] <= seg_q;
                            if (idx == 2'd3) state_q <= DONE;
                            else             expect_q <= expect_q + 2'd1;
                        end else begin
                            seq_err <= 1'b1;
                            if (idx == 2'd0) begin
                                buf_q[~sel_q][0] <= seg_q;
                                expect_q         <= 2'd1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (swap) begin
                        sel_q      <= ~sel_q;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        blank      <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A stalled driver abandons any partial frame; a pending swap still completes.
            if (tmo_hit && !swap) begin
                blank   <= 1'b1;
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sm510_lcd_capture.sv
// Directed bench for sm510_lcd_capture: frames are queued on a scoreboard as driven and checked at frame_done.
module tb_sm510_lcd_capture;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  H;
    logic [15:0] segA, segB;
    logic        Bs, freeze;
    logic [1:0]  rd_row;
    logic [32:0] rd_data;
    logic        frame_done, seq_err, blank;
    logic [7:0]  frame_cnt;

    sm510_lcd_capture #(.SETTLE(2), .TIMEOUT(24'(TMO))) dut (
        .clk(clk), .rst(rst), .H(H), .segA(segA), .segB(segB), .Bs(Bs),
        .freeze(freeze), .rd_row(rd_row), .rd_data(rd_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .seq_err(seq_err), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       cnt;
        logic [3:0][32:0] rows;
    } frame_t;

    frame_t           sb_q[$];
    logic [3:0][32:0] model_front;
    logic [7:0]       exp_cnt;
    int n_assert = 0, n_fail = 0, n_done = 0, n_seq = 0;
    int d0, s0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] exp_row(input int r, input logic [7:0] salt);
        logic [15:0] a, b;
        logic [1:0]  rr;
        rr = r[1:0];
        a  = 16'h1111 * 16'(r);
        b  = {salt, 6'd0, rr};
        return {rr[0] ^ salt[0], b, a};
    endfunction

    task automatic drive_row(input int r, input logic [7:0] salt, input int hold);
        H = 4'b0001 << r;
        {Bs, segB, segA} = exp_row(r, salt);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] salt);
        frame_t rec;
        exp_cnt = exp_cnt + 8'd1;
        rec.cnt = exp_cnt;
        for (int r = 0; r < 4; r++) rec.rows[r] = exp_row(r, salt);
        sb_q.push_back(rec);
    endtask

    task automatic frame(input logic [7:0] salt, input bit push);
        if (push) push_frame(salt);
        for (int r = 0; r < 4; r++) drive_row(r, salt, 4);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input int r, input logic [32:0] exp);
        rd_row = r[1:0];
        @(posedge clk);
        @(negedge clk);
        chk(tag, rd_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        wait_cyc(2);
        sb_q.delete();
        model_front = '0;
        exp_cnt = 8'd0;
    endtask

    // Scoreboard side: every frame_done must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst && seq_err) n_seq++;
        if (rst && frame_done) begin
            n_done++;
            chk("frame_expected", 33'(sb_q.size() > 0), 33'd1);
            if (sb_q.size() > 0) begin
                frame_t rec;
                rec = sb_q.pop_front();
                chk("frame_cnt", frame_cnt, rec.cnt);
                chk("blank_at_done", blank, 1'b0);
                model_front = rec.rows;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        H = 4'd0; segA = 16'd0; segB = 16'd0; Bs = 1'b0; freeze = 1'b0; rd_row = 2'd0;
        rst = 1'b0;
        model_front = '0;
        exp_cnt = 8'd0;
        wait_cyc(3);
        chk("rst_rd_data", rd_data, 33'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        chk("rst_seq_err", seq_err, 1'b0);
        chk("rst_blank", blank, 1'b1);
        rst = 1'b1;
        wait_cyc(2);

        // Normal frame; frame_done 1+SETTLE+1 clk after H=8 is registered (sixth negedge after driving).
        push_frame(8'h01);
        for (int r = 0; r < 3; r++) drive_row(r, 8'h01, 4);
        drive_row(3, 8'h01, 0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("done_latency_%0d", i), frame_done, 33'(i == 6));
        end
        @(posedge clk); #1;
        chk("cnt_after_first", frame_cnt, 8'd1);
        chk("blank_after_first", blank, 1'b0);
        read_chk("row2_first", 2, exp_row(2, 8'h01));
        chk("row2_segA", model_front[2][15:0], 33'h2222);

        // Glitch: 1-cycle H=2 and a gap between commons 0 and 1.
        d0 = n_done; s0 = n_seq;
        push_frame(8'h02);
        drive_row(0, 8'h02, 4);
        H = 4'b0010; wait_cyc(1);
        H = 4'b0000; wait_cyc(1);
        for (int r = 1; r < 4; r++) drive_row(r, 8'h02, 4);
        wait_cyc(4);
        chk("glitch_no_seq_err", n_seq, s0);
        chk("glitch_done", n_done, d0 + 1);
        read_chk("glitch_row1", 1, exp_row(1, 8'h02));

        // Out of order: 1,4 then 8 must not complete; a clean frame afterwards does.
        d0 = n_done; s0 = n_seq;
        drive_row(0, 8'h03, 4);
        drive_row(2, 8'h03, 4);
        drive_row(3, 8'h03, 6);
        chk("ooo_seq_err", n_seq, s0 + 1);
        chk("ooo_no_done", n_done, d0);
        frame(8'h04, 1'b1);
        wait_cyc(4);
        chk("ooo_recover_done", n_done, d0 + 1);
        read_chk("ooo_row3", 3, exp_row(3, 8'h04));

        // Freeze before row 3: swap deferred, a second frame is ignored.
        d0 = n_done;
        push_frame(8'h05);
        for (int r = 0; r < 3; r++) drive_row(r, 8'h05, 4);
        freeze = 1'b1;
        drive_row(3, 8'h05, 10);
        chk("freeze_no_done", n_done, d0);
        read_chk("freeze_front_held", 0, exp_row(0, 8'h04));
        frame(8'h06, 1'b0);
        wait_cyc(2);
        chk("freeze_still_no_done", n_done, d0);
        freeze = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk($sformatf("unfreeze_done_%0d", i), frame_done, 33'(i == 2));
        end
        @(posedge clk); #1;
        read_chk("unfreeze_row0", 0, exp_row(0, 8'h05));
        read_chk("unfreeze_row3", 3, exp_row(3, 8'h05));

        // Timeout: blank rises TMO clk after the change is seen (input reg + change detect add two).
        drive_row(2, 8'h07, 0);
        for (int i = 1; i <= TMO + 3; i++) begin
            @(negedge clk);
            if (i == TMO + 2) chk("blank_before_tmo", blank, 1'b0);
            if (i == TMO + 3) chk("blank_at_tmo", blank, 1'b1);
        end
        @(posedge clk); #1;
        read_chk("tmo_front_kept", 1, exp_row(1, 8'h05));
        d0 = n_done;
        frame(8'h08, 1'b1);
        wait_cyc(4);
        chk("tmo_recover_done", n_done, d0 + 1);
        chk("tmo_blank_cleared", blank, 1'b0);

        // Wrap: 256 frames from reset bring frame_cnt back to 0.
        reset_dut();
        rst = 1'b1;
        wait_cyc(1);
        for (int f = 0; f < 256; f++) frame(8'(f), 1'b1);
        wait_cyc(4);
        chk("wrap_cnt", frame_cnt, 8'd0);
        chk("wrap_sb_empty", 33'(sb_q.size()), 33'd0);

        // Reset during row 2 discards the partial frame.
        drive_row(0, 8'h09, 4);
        drive_row(1, 8'h09, 4);
        drive_row(2, 8'h09, 2);
        d0 = n_done;
        reset_dut();
        chk("midrst_rd_data", rd_data, 33'd0);
        chk("midrst_frame_done", frame_done, 1'b0);
        chk("midrst_frame_cnt", frame_cnt, 8'd0);
        chk("midrst_seq_err", seq_err, 1'b0);
        chk("midrst_blank", blank, 1'b1);
        rst = 1'b1;
        drive_row(2, 8'h09, 4);
        drive_row(3, 8'h09, 8);
        chk("midrst_no_done", n_done, d0);
        chk("midrst_blank_held", blank, 1'b1);
        read_chk("midrst_front_clear", 2, 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
